// File: rtl/adc_frame_rx.sv
// adc_frame_rx: frame controller and 4-lane deserializer for a pair of
// AD7352 dual-channel 12-bit ADCs. The ADC SCLK is clk. The ADCs launch data
// on the falling edge, and this block samples it on the rising edge.
// Each frame has the following layout:
//   - one leading zero;
//   - 12 data bits, MSB first;
//   - one trailing zero, sampled on the edge that raises ad_cs.
// The frame is followed by CS_HIGH quiet cycles.

module adc_frame_rx #(
  parameter int CS_HIGH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        ad_cs,
  input  logic [1:0]  ad_sdata_a,
  input  logic [1:0]  ad_sdata_b,
  output logic [11:0] vcap,
  output logic [11:0] icap,
  output logic [11:0] vout,
  output logic [11:0] iout,
  output logic        sample_valid,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2
  } state_t;

  // Last cnt value of QUIET: CS_HIGH high cycles counted from the edge that raised ad_cs.
  localparam logic [3:0] QUIET_LAST = 4'(CS_HIGH - 1);
  localparam logic [3:0] CONV_LAST  = 4'd13;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic        ad_cs_s;
  logic        lead_s;
  logic        shift_s;
  logic        end_s;
  logic        arm_r;
  logic        err_r;
  logic        any_one_s;
  logic [11:0] sh_vcap_r;
  logic [11:0] sh_icap_r;
  logic [11:0] sh_vout_r;
  logic [11:0] sh_iout_r;

  assign any_one_s = |{ad_sdata_a, ad_sdata_b};

  // After reset release, hold off the first frame for one full IDLE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm_r <= 1'b0;
    end else begin
      arm_r <= 1'b1;
    end
  end

  // State register, cycle counter and registered chip select.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ad_cs   <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ad_cs   <= ad_cs_s;
    end
  end

  // Next-state logic and the per-edge datapath controls.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ad_cs_s = 1'b1;
    lead_s  = 1'b0;
    shift_s = 1'b0;
    end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && arm_r) begin
          state_s = CONV;
          cnt_s   = 4'd0;
          ad_cs_s = 1'b0;
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      CONV: begin
        if (cnt_r == CONV_LAST) begin
          // E14: trailing zero sampled, frame published, chip select raised.
          end_s   = 1'b1;
          state_s = QUIET;
          cnt_s   = 4'd0;
          ad_cs_s = 1'b1;
        end else begin
          ad_cs_s = 1'b0;
          cnt_s   = cnt_r + 4'd1;
          if (cnt_r == 4'd0) begin
            lead_s = 1'b1;
          end else begin
            shift_s = 1'b1;
          end
        end
      end
      QUIET: begin
        if (cnt_r == QUIET_LAST) begin
          cnt_s = 4'd0;
          if (enable) begin
            state_s = CONV;
            ad_cs_s = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Framing-zero checks: a leading 1 sets the error bit, and the trailing zero is folded in at E14.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (lead_s) begin
      err_r <= any_one_s;
    end else begin
      err_r <= err_r;
    end
  end

  // MSB-first shift registers, one per ADC lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_vcap_r <= 12'd0;
      sh_icap_r <= 12'd0;
      sh_vout_r <= 12'd0;
      sh_iout_r <= 12'd0;
    end else if (shift_s) begin
      sh_vcap_r <= {sh_vcap_r[10:0], ad_sdata_b[1]};
      sh_icap_r <= {sh_icap_r[10:0], ad_sdata_b[0]};
      sh_vout_r <= {sh_vout_r[10:0], ad_sdata_a[1]};
      sh_iout_r <= {sh_iout_r[10:0], ad_sdata_a[0]};
    end else begin
      sh_vcap_r <= sh_vcap_r;
      sh_icap_r <= sh_icap_r;
      sh_vout_r <= sh_vout_r;
      sh_iout_r <= sh_iout_r;
    end
  end

  // Publish the codes and strobes at the end of each frame; the codes hold between frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vcap         <= 12'd0;
      icap         <= 12'd0;
      vout         <= 12'd0;
      iout         <= 12'd0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else if (end_s) begin
      vcap         <= sh_vcap_r;
      icap         <= sh_icap_r;
      vout         <= sh_vout_r;
      iout         <= sh_iout_r;
      sample_valid <= 1'b1;
      frame_err    <= err_r | any_one_s;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_frame_rx.sv
// tb_adc_frame_rx: directed bench for adc_frame_rx.
// There are two instances:
//   - u_dut uses the default CS_HIGH = 2;
//   - u_dut2 uses CS_HIGH = 1.
// Each instance has its own behavioural AD7352 pair. The model drives lines on
// the falling edge and latches the target codes at the first falling edge
// after ad_cs drops. It puts random bits on the lines while ad_cs is high.

module tb_adc_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        enable;
  logic        enable2;
  logic        ad_cs;
  logic        ad_cs2;
  logic [1:0]  sa;
  logic [1:0]  sb;
  logic [1:0]  sa2;
  logic [1:0]  sb2;
  logic [11:0] vcap, icap, vout, iout;
  logic [11:0] vcap2, icap2, vout2, iout2;
  logic        sample_valid, frame_err;
  logic        sample_valid2, frame_err2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model target codes (what the converters see) and fault injection.
  logic [11:0] v_vcap = 12'd0, v_icap = 12'd0, v_vout = 12'd0, v_iout = 12'd0;
  logic [11:0] w_vcap = 12'd0, w_icap = 12'd0, w_vout = 12'd0, w_iout = 12'd0;
  logic        inj_lead  = 1'b0;
  logic        inj_trail = 1'b0;

  logic [11:0] s1_vcap, s1_icap, s1_vout, s1_iout;
  logic [11:0] s2_vcap, s2_icap, s2_vout, s2_iout;
  logic [4:0]  m1 = 5'd0;
  logic [4:0]  m2 = 5'd0;

  adc_frame_rx u_dut (
    .clk(clk), .reset(reset), .enable(enable), .ad_cs(ad_cs),
    .ad_sdata_a(sa), .ad_sdata_b(sb),
    .vcap(vcap), .icap(icap), .vout(vout), .iout(iout),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  adc_frame_rx #(.CS_HIGH(1)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .ad_cs(ad_cs2),
    .ad_sdata_a(sa2), .ad_sdata_b(sb2),
    .vcap(vcap2), .icap(icap2), .vout(vout2), .iout(iout2),
    .sample_valid(sample_valid2), .frame_err(frame_err2)
  );

  // ADC pair model for u_dut: lead zero, 12 bits MSB first, trailing zero.
  always @(negedge clk) begin
    if (ad_cs) begin
      m1 <= 5'd0;
      sa <= 2'($urandom);
      sb <= 2'($urandom);
    end else begin
      if (m1 != 5'd31) m1 <= m1 + 5'd1;
      if (m1 == 5'd0) begin
        s1_vcap <= v_vcap; s1_icap <= v_icap; s1_vout <= v_vout; s1_iout <= v_iout;
        sb <= 2'b00;
        sa <= {1'b0, inj_lead};
      end else if (m1 <= 5'd12) begin
        sb <= {s1_vcap[11], s1_icap[11]};
        sa <= {s1_vout[11], s1_iout[11]};
        s1_vcap <= {s1_vcap[10:0], 1'b0}; s1_icap <= {s1_icap[10:0], 1'b0};
        s1_vout <= {s1_vout[10:0], 1'b0}; s1_iout <= {s1_iout[10:0], 1'b0};
      end else begin
        sb <= 2'b00;
        sa <= {inj_trail, 1'b0};
      end
    end
  end

  // ADC pair model for u_dut2 (no fault injection).
  always @(negedge clk) begin
    if (ad_cs2) begin
      m2  <= 5'd0;
      sa2 <= 2'($urandom);
      sb2 <= 2'($urandom);
    end else begin
      if (m2 != 5'd31) m2 <= m2 + 5'd1;
      if (m2 == 5'd0) begin
        s2_vcap <= w_vcap; s2_icap <= w_icap; s2_vout <= w_vout; s2_iout <= w_iout;
        sb2 <= 2'b00;
        sa2 <= 2'b00;
      end else if (m2 <= 5'd12) begin
        sb2 <= {s2_vcap[11], s2_icap[11]};
        sa2 <= {s2_vout[11], s2_iout[11]};
        s2_vcap <= {s2_vcap[10:0], 1'b0}; s2_icap <= {s2_icap[10:0], 1'b0};
        s2_vout <= {s2_vout[10:0], 1'b0}; s2_iout <= {s2_iout[10:0], 1'b0};
      end else begin
        sb2 <= 2'b00;
        sa2 <= 2'b00;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sv(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sv2(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      if (sample_valid2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ad_cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", ad_cs); end
    n_cmp++; if ({vcap, icap, vout, iout} !== 48'd0) begin n_fail++; $display("FAIL reset_codes: got %h want 0", {vcap, icap, vout, iout}); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sv: got %b want 0", sample_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
    n_cmp++; if (ad_cs2 !== 1'b1) begin n_fail++; $display("FAIL reset_cs2: got %b want 1", ad_cs2); end
    reset = 1'b1;
    repeat (2) tick();
    n_cmp++; if (ad_cs !== 1'b1) begin n_fail++; $display("FAIL idle_cs: got %b want 1", ad_cs); end
  endtask

  task automatic test_basic();
    bit ok; int cyc; int per; int lows; logic sv_after;
    v_vcap = 12'hA00; v_icap = 12'h000; v_vout = 12'h0A0; v_iout = 12'h200;
    enable = 1'b1;
    tick();
    n_cmp++; if (ad_cs !== 1'b0) begin n_fail++; $display("FAIL basic_e0: cs got %b want 0", ad_cs); end
    wait_sv(30, ok, cyc);
    n_cmp++; if (!ok || cyc != 14) begin n_fail++; $display("FAIL basic_latency: got ok=%0d cyc=%0d want 14", ok, cyc); end
    n_cmp++; if (vcap !== 12'hA00) begin n_fail++; $display("FAIL basic_vcap: got %h want a00", vcap); end
    n_cmp++; if (icap !== 12'h000) begin n_fail++; $display("FAIL basic_icap: got %h want 000", icap); end
    n_cmp++; if (vout !== 12'h0A0) begin n_fail++; $display("FAIL basic_vout: got %h want 0a0", vout); end
    n_cmp++; if (iout !== 12'h200) begin n_fail++; $display("FAIL basic_iout: got %h want 200", iout); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", frame_err); end
    per = 0; lows = 0; sv_after = 1'bx;
    do begin
      tick();
      per++;
      if (per == 1) sv_after = sample_valid;
      if (!ad_cs) lows++;
    end while (!sample_valid && per < 40);
    n_cmp++; if (sv_after !== 1'b0) begin n_fail++; $display("FAIL basic_sv_width: got %b want 0", sv_after); end
    n_cmp++; if (per != 16) begin n_fail++; $display("FAIL basic_period: got %0d want 16", per); end
    n_cmp++; if (lows != 14) begin n_fail++; $display("FAIL basic_cs_low: got %0d want 14", lows); end
    n_cmp++; if ({vcap, icap, vout, iout} !== {12'hA00, 12'h000, 12'h0A0, 12'h200}) begin n_fail++; $display("FAIL basic_frame2: got %h", {vcap, icap, vout, iout}); end
  endtask

  task automatic test_walking();
    bit ok; int cyc;
    v_vcap = 12'h800; v_icap = 12'h001; v_vout = 12'h555; v_iout = 12'hAAA;
    wait_sv(40, ok, cyc);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL walk1_timeout: no sample_valid"); end
    n_cmp++; if (vcap !== 12'h800) begin n_fail++; $display("FAIL walk1_vcap: got %h want 800", vcap); end
    n_cmp++; if (icap !== 12'h001) begin n_fail++; $display("FAIL walk1_icap: got %h want 001", icap); end
    n_cmp++; if (vout !== 12'h555) begin n_fail++; $display("FAIL walk1_vout: got %h want 555", vout); end
    n_cmp++; if (iout !== 12'hAAA) begin n_fail++; $display("FAIL walk1_iout: got %h want aaa", iout); end
    v_vcap = 12'h001; v_icap = 12'h800; v_vout = 12'hAAA; v_iout = 12'h555;
    wait_sv(40, ok, cyc);
    n_cmp++; if (!ok || {vcap, icap, vout, iout} !== {12'h001, 12'h800, 12'hAAA, 12'h555}) begin n_fail++; $display("FAIL walk2_codes: got %h want 001800aaa555", {vcap, icap, vout, iout}); end
  endtask

  task automatic test_frame_err();
    bit ok; int cyc;
    v_vcap = 12'h123; v_icap = 12'h456; v_vout = 12'h789; v_iout = 12'hABC;
    inj_lead = 1'b1;
    wait_sv(40, ok, cyc);
    inj_lead = 1'b0;
    n_cmp++; if (!ok || frame_err !== 1'b1) begin n_fail++; $display("FAIL lead_err: got ok=%0d err=%b want 1", ok, frame_err); end
    n_cmp++; if ({vcap, icap, vout, iout} !== {12'h123, 12'h456, 12'h789, 12'hABC}) begin n_fail++; $display("FAIL lead_codes: got %h want 123456789abc", {vcap, icap, vout, iout}); end
    tick();
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL err_width: got %b want 0", frame_err); end
    wait_sv(40, ok, cyc);
    n_cmp++; if (!ok || frame_err !== 1'b0) begin n_fail++; $display("FAIL clean_after_lead: got ok=%0d err=%b want 0", ok, frame_err); end
    inj_trail = 1'b1;
    wait_sv(40, ok, cyc);
    inj_trail = 1'b0;
    n_cmp++; if (!ok || frame_err !== 1'b1) begin n_fail++; $display("FAIL trail_err: got ok=%0d err=%b want 1", ok, frame_err); end
    wait_sv(40, ok, cyc);
    n_cmp++; if (!ok || frame_err !== 1'b0) begin n_fail++; $display("FAIL clean_after_trail: got ok=%0d err=%b want 0", ok, frame_err); end
  endtask

  task automatic test_drop_enable();
    bit ok; int cyc; int lows;
    v_vcap = 12'h0FF; v_icap = 12'hF00; v_vout = 12'h0F0; v_iout = 12'h00F;
    repeat (2) tick();
    n_cmp++; if (ad_cs !== 1'b0) begin n_fail++; $display("FAIL drop_e0: cs got %b want 0", ad_cs); end
    repeat (5) tick();
    enable = 1'b0;
    wait_sv(30, ok, cyc);
    n_cmp++; if (!ok || cyc != 9) begin n_fail++; $display("FAIL drop_complete: got ok=%0d cyc=%0d want 9", ok, cyc); end
    n_cmp++; if ({vcap, icap, vout, iout} !== {12'h0FF, 12'hF00, 12'h0F0, 12'h00F}) begin n_fail++; $display("FAIL drop_codes: got %h", {vcap, icap, vout, iout}); end
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!ad_cs) lows++;
    end
    n_cmp++; if (lows != 0) begin n_fail++; $display("FAIL drop_idle: cs low %0d cycles want 0", lows); end
    v_vcap = 12'hFFF; v_icap = 12'h7FE; v_vout = 12'h000; v_iout = 12'h801;
    enable = 1'b1;
    tick();
    n_cmp++; if (ad_cs !== 1'b0) begin n_fail++; $display("FAIL restart_e0: cs got %b want 0", ad_cs); end
    wait_sv(30, ok, cyc);
    n_cmp++; if (!ok || cyc != 14 || {vcap, icap, vout, iout} !== {12'hFFF, 12'h7FE, 12'h000, 12'h801}) begin n_fail++; $display("FAIL restart_frame: got ok=%0d cyc=%0d codes=%h", ok, cyc, {vcap, icap, vout, iout}); end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc; int svs;
    repeat (2) tick();
    n_cmp++; if (ad_cs !== 1'b0) begin n_fail++; $display("FAIL rst_e0: cs got %b want 0", ad_cs); end
    repeat (8) tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (ad_cs !== 1'b1) begin n_fail++; $display("FAIL rst_async_cs: got %b want 1", ad_cs); end
    n_cmp++; if ({vcap, icap, vout, iout} !== 48'd0) begin n_fail++; $display("FAIL rst_codes: got %h want 0", {vcap, icap, vout, iout}); end
    svs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sample_valid) svs++;
    end
    n_cmp++; if (svs != 0) begin n_fail++; $display("FAIL rst_no_sv: got %0d pulses want 0", svs); end
    v_vcap = 12'h3C3; v_icap = 12'h0C3; v_vout = 12'hC3C; v_iout = 12'h3C0;
    reset = 1'b1;
    tick();
    n_cmp++; if (ad_cs !== 1'b1) begin n_fail++; $display("FAIL rst_idle_cycle: cs got %b want 1", ad_cs); end
    wait_sv(30, ok, cyc);
    n_cmp++; if (!ok || cyc != 15) begin n_fail++; $display("FAIL rst_refr_latency: got ok=%0d cyc=%0d want 15", ok, cyc); end
    n_cmp++; if ({vcap, icap, vout, iout, frame_err} !== {12'h3C3, 12'h0C3, 12'hC3C, 12'h3C0, 1'b0}) begin n_fail++; $display("FAIL rst_refr_codes: got %h err=%b", {vcap, icap, vout, iout}, frame_err); end
    enable = 1'b0;
  endtask

  task automatic test_cs_high1();
    bit ok; int cyc; int per; int lows;
    w_vcap = 12'hA00; w_icap = 12'h000; w_vout = 12'h0A0; w_iout = 12'h200;
    enable2 = 1'b1;
    wait_sv2(40, ok, cyc);
    n_cmp++; if (!ok || cyc != 15) begin n_fail++; $display("FAIL cs1_first: got ok=%0d cyc=%0d want 15", ok, cyc); end
    n_cmp++; if ({vcap2, icap2, vout2, iout2} !== {12'hA00, 12'h000, 12'h0A0, 12'h200}) begin n_fail++; $display("FAIL cs1_codes1: got %h", {vcap2, icap2, vout2, iout2}); end
    per = 0; lows = 0;
    do begin
      tick();
      per++;
      if (!ad_cs2) lows++;
    end while (!sample_valid2 && per < 40);
    n_cmp++; if (per != 15) begin n_fail++; $display("FAIL cs1_period: got %0d want 15", per); end
    n_cmp++; if (lows != 14) begin n_fail++; $display("FAIL cs1_cs_low: got %0d want 14", lows); end
    w_vcap = 12'h800; w_icap = 12'h001; w_vout = 12'h555; w_iout = 12'hAAA;
    wait_sv2(40, ok, cyc);
    n_cmp++; if (!ok || cyc != 15 || {vcap2, icap2, vout2, iout2} !== {12'h800, 12'h001, 12'h555, 12'hAAA}) begin n_fail++; $display("FAIL cs1_codes2: got ok=%0d cyc=%0d codes=%h", ok, cyc, {vcap2, icap2, vout2, iout2}); end
    n_cmp++; if (frame_err2 !== 1'b0) begin n_fail++; $display("FAIL cs1_err: got %b want 0", frame_err2); end
    enable2 = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
    test_reset();
    test_basic();
    test_walking();
    test_frame_err();
    test_drop_enable();
    test_reset_mid();
    test_cs_high1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
